// File: rtl/truth_table_sweeper.sv
// Exhaustive 4-input truth-table sweeper: drives all 16 vectors, samples F,
// and compares the measured table against a caller-supplied expected table.
module truth_table_sweeper #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    output logic [3:0]  abcd,
    input  logic        f_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] table_out,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_fail_idx
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t      state;
    logic [15:0] exp_q;
    logic [3:0]  idx;
    logic [7:0]  hold;
    logic        miss;
    logic [4:0]  count_next;

    assign miss       = f_in != exp_q[idx];
    assign count_next = mismatch_count + {4'd0, miss};

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            exp_q          <= '0;
            idx            <= '0;
            hold           <= '0;
            abcd           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            table_out      <= '0;
            mismatch_count <= '0;
            first_fail_idx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state          <= RUN;
                        exp_q          <= expected;
                        idx            <= '0;
                        hold           <= '0;
                        abcd           <= '0;
                        busy           <= 1'b1;
                        pass           <= 1'b0;
                        table_out      <= '0;
                        mismatch_count <= '0;
                        first_fail_idx <= '0;
                    end
                end
                RUN: begin
                    // F is only trusted at the end of its settle window
                    if (hold == HOLD_LAST) begin
                        hold           <= '0;
                        table_out[idx] <= f_in;
                        mismatch_count <= count_next;
                        if (miss && mismatch_count == 5'd0)
                            first_fail_idx <= idx;
                        if (idx == 4'd15) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (count_next == 5'd0);
                            abcd  <= '0;
                        end else begin
                            idx  <= idx + 4'd1;
                            abcd <= idx + 4'd1;
                        end
                    end else begin
                        hold <= hold + 8'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: table of sweeps on an H=4 instance,
// an H=1 sweep, ignored start pulses and reset abort.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start4 = 1'b0;
    logic [15:0] exp4 = '0;
    logic [1:0]  mode4 = 2'd0;
    logic [3:0]  abcd4;
    logic        f4;
    logic        busy4, done4, pass4;
    logic [15:0] tab4;
    logic [4:0]  cnt4;
    logic [3:0]  ffi4;

    logic        start1 = 1'b0;
    logic [15:0] exp1 = '0;
    logic [1:0]  mode1 = 2'd0;
    logic [3:0]  abcd1;
    logic        f1;
    logic        busy1, done1, pass1;
    logic [15:0] tab1;
    logic [4:0]  cnt1;
    logic [3:0]  ffi1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // function under test: 0 = A^B^C^D, 1 = tied high, 2 = tied low
    assign f4 = (mode4 == 2'd0) ? ^abcd4 : (mode4 == 2'd1);
    assign f1 = (mode1 == 2'd0) ? ^abcd1 : (mode1 == 2'd1);

    truth_table_sweeper #(.HOLD_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .expected(exp4),
        .abcd(abcd4), .f_in(f4), .busy(busy4), .done(done4),
        .pass(pass4), .table_out(tab4), .mismatch_count(cnt4),
        .first_fail_idx(ffi4)
    );

    truth_table_sweeper #(.HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .expected(exp1),
        .abcd(abcd1), .f_in(f1), .busy(busy1), .done(done1),
        .pass(pass1), .table_out(tab1), .mismatch_count(cnt1),
        .first_fail_idx(ffi1)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] expected;
        logic [15:0] table_exp;
        logic        pass_exp;
        logic [4:0]  cnt_exp;
        logic [3:0]  ffi_exp;
        bit          poke;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic sel_busy(input int w);
        return (w == 0) ? busy4 : busy1;
    endfunction

    function automatic logic sel_done(input int w);
        return (w == 0) ? done4 : done1;
    endfunction

    function automatic logic [3:0] sel_abcd(input int w);
        return (w == 0) ? abcd4 : abcd1;
    endfunction

    task automatic set_start(input int w, input logic v);
        if (w == 0) start4 = v;
        else start1 = v;
    endtask

    // Launches one sweep; checks busy rise, vector stepping, done latency
    // and that no second done or busy follows.
    task automatic run_sweep(input int w, input int h, input logic [1:0] m,
                             input logic [15:0] e, input bit poke);
        int c;
        int bad;
        int extra;
        if (w == 0) begin mode4 = m; exp4 = e; end
        else begin mode1 = m; exp1 = e; end
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        check("busy_rise", 32'(sel_busy(w)), 32'd1);
        c = 0;
        bad = 0;
        while (!sel_done(w) && c < 16 * h + 10) begin
            if (sel_abcd(w) != 4'(c / h)) bad++;
            set_start(w, poke && (c == 3 || c == 9 || c == 17 ||
                                  c == 30 || c == 45));
            @(negedge clk);
            c++;
        end
        set_start(w, 1'b0);
        check("done_latency", 32'(c), 32'(16 * h));
        check("abcd_steps", 32'(bad), 32'd0);
        check("busy_at_done", 32'(sel_busy(w)), 32'd0);
        check("abcd_at_done", 32'(sel_abcd(w)), 32'd0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sel_done(w) || sel_busy(w)) extra++;
        end
        check("single_done", 32'(extra), 32'd0);
    endtask

    initial begin
        vecs[0] = '{2'd0, 16'h6996, 16'h6996, 1'b1, 5'd0,  4'd0,  1'b0};
        vecs[1] = '{2'd0, 16'h6997, 16'h6996, 1'b0, 5'd1,  4'd0,  1'b0};
        vecs[2] = '{2'd0, 16'h9669, 16'h6996, 1'b0, 5'd16, 4'd0,  1'b0};
        vecs[3] = '{2'd1, 16'hFF00, 16'hFFFF, 1'b0, 5'd8,  4'd0,  1'b0};
        vecs[4] = '{2'd2, 16'h0800, 16'h0000, 1'b0, 5'd1,  4'd11, 1'b0};
        vecs[5] = '{2'd0, 16'h6996, 16'h6996, 1'b1, 5'd0,  4'd0,  1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_abcd", 32'(abcd4), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_done", 32'(done4), 32'd0);
        check("rst_pass", 32'(pass4), 32'd0);
        check("rst_table", 32'(tab4), 32'd0);
        check("rst_cnt", 32'(cnt4), 32'd0);
        check("rst_ffi", 32'(ffi4), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_sweep(0, 4, vecs[i].mode, vecs[i].expected, vecs[i].poke);
            check($sformatf("v%0d_table", i), 32'(tab4), 32'(vecs[i].table_exp));
            check($sformatf("v%0d_pass", i), 32'(pass4), 32'(vecs[i].pass_exp));
            check($sformatf("v%0d_cnt", i), 32'(cnt4), 32'(vecs[i].cnt_exp));
            check($sformatf("v%0d_ffi", i), 32'(ffi4), 32'(vecs[i].ffi_exp));
        end

        run_sweep(1, 1, 2'd0, 16'h6996, 1'b0);
        check("h1_table", 32'(tab1), 32'h6996);
        check("h1_pass", 32'(pass1), 32'd1);
        check("h1_cnt", 32'(cnt1), 32'd0);

        // back-to-back: start held high restarts after one idle cycle
        exp1 = 16'h6996;
        start1 = 1'b1;
        @(negedge clk);
        while (!done1 && busy1) @(negedge clk);
        check("b2b_done", 32'(done1), 32'd1);
        @(negedge clk);
        check("b2b_idle_gap", 32'(busy1), 32'd0);
        @(negedge clk);
        start1 = 1'b0;
        check("b2b_restart", 32'(busy1), 32'd1);
        repeat (20) @(negedge clk);

        // reset in the middle of a sweep
        exp4 = 16'h0000;
        mode4 = 2'd1;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_rst_busy", 32'(busy4), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_abcd", 32'(abcd4), 32'd0);
        check("mid_rst_busy", 32'(busy4), 32'd0);
        check("mid_rst_done", 32'(done4), 32'd0);
        check("mid_rst_table", 32'(tab4), 32'd0);
        check("mid_rst_cnt", 32'(cnt4), 32'd0);
        check("mid_rst_ffi", 32'(ffi4), 32'd0);
        check("mid_rst_pass", 32'(pass4), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_no_done", 32'(done4 | busy4), 32'd0);
        end
        rst = 1'b0;
        run_sweep(0, 4, 2'd2, 16'h0800, 1'b0);
        check("post_rst_table", 32'(tab4), 32'd0);
        check("post_rst_cnt", 32'(cnt4), 32'd1);
        check("post_rst_ffi", 32'(ffi4), 32'd11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
